knn_ctrl: RTL and testbench

//  Sequencer for the knn solver array. Loads one test point per solver, streams training points to all solvers,

---
 rtl/knn_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_knn_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_ctrl.sv
// knn_ctrl: sequences test-point load, training stream, result readback and clear
// for the knn solver array; every knn core control input comes from a flop here.
module knn_ctrl #(
  parameter int DATA_W     = 32,
  parameter int N_SOLVERS  = 4,
  parameter int HW_K       = 10,
  parameter int SETTLE_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [15:0]                  n_train,
  output logic                         busy,
  output logic                         done,
  input  logic [DATA_W-1:0]            test_data,
  input  logic                         test_valid,
  output logic                         test_ready,
  input  logic [DATA_W-1:0]            train_data,
  input  logic                         train_valid,
  output logic                         train_ready,
  output logic [15:0]                  res_data,
  output logic [$clog2(N_SOLVERS)-1:0] res_solver,
  output logic [$clog2(HW_K)-1:0]      res_k,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         core_valid,
  output logic                         core_done,
  output logic [15:0]                  core_sel,
  output logic [15:0]                  core_solver_sel,
  output logic [DATA_W-1:0]            core_data_1,
  output logic [DATA_W-1:0]            core_data_2,
  input  logic [15:0]                  core_data_out,
  output logic                         core_clr
);

  localparam int SW = $clog2(N_SOLVERS);
  localparam int KW = $clog2(HW_K);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, SETTLE, READ, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [15:0]         n_train_q, n_train_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [SW-1:0]       s_q, s_d;
  logic [KW-1:0]       k_q, k_d;
  logic                cap_q, cap_d;
  logic                last_res;

  logic                busy_q, busy_d, done_q, done_d;
  logic                test_ready_q, test_ready_d, train_ready_q, train_ready_d;
  logic [15:0]         res_data_q, res_data_d;
  logic [SW-1:0]       res_solver_q, res_solver_d;
  logic [KW-1:0]       res_k_q, res_k_d;
  logic                res_valid_q, res_valid_d;
  logic                core_valid_q, core_valid_d, core_done_q, core_done_d;
  logic [15:0]         core_sel_q, core_sel_d, core_solver_sel_q, core_solver_sel_d;
  logic [DATA_W-1:0]   core_data_1_q, core_data_1_d, core_data_2_q, core_data_2_d;
  logic                core_clr_q, core_clr_d;

  always_comb begin
    state_d           = state_q;
    n_train_d         = n_train_q;
    cnt_d             = cnt_q;
    s_d               = s_q;
    k_d               = k_q;
    cap_d             = 1'b0;
    last_res          = 1'b0;
    busy_d            = busy_q;
    done_d            = 1'b0;
    test_ready_d      = test_ready_q;
    train_ready_d     = train_ready_q;
    res_data_d        = res_data_q;
    res_solver_d      = res_solver_q;
    res_k_d           = res_k_q;
    res_valid_d       = res_valid_q;
    core_valid_d      = 1'b0;
    core_done_d       = core_done_q;
    core_sel_d        = core_sel_q;
    core_solver_sel_d = core_solver_sel_q;
    core_data_1_d     = core_data_1_q;
    core_data_2_d     = core_data_2_q;
    core_clr_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = LOAD;
          n_train_d    = n_train;
          cnt_d        = '0;
          busy_d       = 1'b1;
          test_ready_d = 1'b1;
        end
      end
      LOAD: begin
        if (test_valid && test_ready_q) begin
          core_solver_sel_d = cnt_q;
          core_data_1_d     = test_data;
          cnt_d             = cnt_q + 16'd1;
          if (cnt_q == 16'(N_SOLVERS - 1)) begin
            test_ready_d = 1'b0;
            cnt_d        = '0;
            if (n_train_q == 16'd0) begin
              state_d = SETTLE;
            end else begin
              state_d       = STREAM;
              train_ready_d = 1'b1;
            end
          end
        end
      end
      STREAM: begin
        if (train_valid && train_ready_q) begin
          core_valid_d  = 1'b1;
          core_data_2_d = train_data;
          cnt_d         = cnt_q + 16'd1;
          if (cnt_q == n_train_q - 16'd1) begin
            train_ready_d = 1'b0;
            cnt_d         = '0;
            state_d       = SETTLE;
          end
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(SETTLE_CYC - 1)) begin
          cnt_d             = '0;
          state_d           = READ;
          core_done_d       = 1'b1;
          s_d               = '0;
          k_d               = '0;
          core_solver_sel_d = '0;
          core_sel_d        = '0;
          cap_d             = 1'b1;
        end
      end
      // cap_q marks the cycle where core_data_out reflects the selection driven last edge
      READ: begin
        if (cap_q) begin
          res_data_d   = core_data_out;
          res_solver_d = s_q;
          res_k_d      = k_q;
          res_valid_d  = 1'b1;
        end else if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (k_q == KW'(HW_K - 1)) begin
            k_d = '0;
            if (s_q == SW'(N_SOLVERS - 1)) begin
              last_res = 1'b1;
            end else begin
              s_d = s_q + SW'(1);
            end
          end else begin
            k_d = k_q + KW'(1);
          end
          if (last_res) begin
            state_d     = CLEAR;
            core_clr_d  = 1'b1;
            core_done_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            core_solver_sel_d = 16'(s_d);
            core_sel_d        = 16'(k_d);
            cap_d             = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      n_train_q         <= '0;
      cnt_q             <= '0;
      s_q               <= '0;
      k_q               <= '0;
      cap_q             <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      test_ready_q      <= 1'b0;
      train_ready_q     <= 1'b0;
      res_data_q        <= '0;
      res_solver_q      <= '0;
      res_k_q           <= '0;
      res_valid_q       <= 1'b0;
      core_valid_q      <= 1'b0;
      core_done_q       <= 1'b0;
      core_sel_q        <= '0;
      core_solver_sel_q <= '0;
      core_data_1_q     <= '0;
      core_data_2_q     <= '0;
      core_clr_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      n_train_q         <= n_train_d;
      cnt_q             <= cnt_d;
      s_q               <= s_d;
      k_q               <= k_d;
      cap_q             <= cap_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      test_ready_q      <= test_ready_d;
      train_ready_q     <= train_ready_d;
      res_data_q        <= res_data_d;
      res_solver_q      <= res_solver_d;
      res_k_q           <= res_k_d;
      res_valid_q       <= res_valid_d;
      core_valid_q      <= core_valid_d;
      core_done_q       <= core_done_d;
      core_sel_q        <= core_sel_d;
      core_solver_sel_q <= core_solver_sel_d;
      core_data_1_q     <= core_data_1_d;
      core_data_2_q     <= core_data_2_d;
      core_clr_q        <= core_clr_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign test_ready      = test_ready_q;
  assign train_ready     = train_ready_q;
  assign res_data        = res_data_q;
  assign res_solver      = res_solver_q;
  assign res_k           = res_k_q;
  assign res_valid       = res_valid_q;
  assign core_valid      = core_valid_q;
  assign core_done       = core_done_q;
  assign core_sel        = core_sel_q;
  assign core_solver_sel = core_solver_sel_q;
  assign core_data_1     = core_data_1_q;
  assign core_data_2     = core_data_2_q;
  assign core_clr        = core_clr_q;

endmodule

// File: tb/tb_knn_ctrl.sv
// tb_knn_ctrl: drives knn_ctrl with randomized runs against a small stand-in knn core
// and compares every transfer with results predicted from the run's own data.
module tb_knn_ctrl;

  localparam int DW = 32;
  localparam int NS = 2;
  localparam int HK = 4;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   n_train;
  logic          busy, done;
  logic [DW-1:0] test_data, train_data;
  logic          test_valid, test_ready, train_valid, train_ready;
  logic [15:0]   res_data;
  logic [0:0]    res_solver;
  logic [1:0]    res_k;
  logic          res_valid, res_ready;
  logic          core_valid, core_done, core_clr;
  logic [15:0]   core_sel, core_solver_sel, core_data_out;
  logic [DW-1:0] core_data_1, core_data_2;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  knn_ctrl #(.DATA_W(DW), .N_SOLVERS(NS), .HW_K(HK), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .n_train(n_train), .busy(busy), .done(done),
    .test_data(test_data), .test_valid(test_valid), .test_ready(test_ready),
    .train_data(train_data), .train_valid(train_valid), .train_ready(train_ready),
    .res_data(res_data), .res_solver(res_solver), .res_k(res_k),
    .res_valid(res_valid), .res_ready(res_ready),
    .core_valid(core_valid), .core_done(core_done), .core_sel(core_sel),
    .core_solver_sel(core_solver_sel), .core_data_1(core_data_1), .core_data_2(core_data_2),
    .core_data_out(core_data_out), .core_clr(core_clr)
  );

  // Stand-in core: result depends on the solver's test point, the training sum/count and k
  logic [15:0] tp [NS];
  logic [15:0] acc, cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NS; i++) tp[i] <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (core_clr) begin
      for (int i = 0; i < NS; i++) tp[i] <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      if (!core_done) tp[core_solver_sel[0]] <= core_data_1[15:0];
      if (core_valid) begin
        acc <= acc + core_data_2[15:0];
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign core_data_out = tp[core_solver_sel[0]] + acc + {core_sel[7:0], 8'h00} + {cnt[3:0], 12'h000};

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // gap: 0 = random valids, N = train_valid every Nth cycle
  task automatic applyStimulus(input int ntrain, input int gap, input bit basic,
                               input bit bp, input bit noise);
    logic [DW-1:0] tw [NS];
    logic [DW-1:0] trw [$];
    logic [15:0]   expq [$];
    int            sidq [$];
    int            kidq [$];
    int            sum = 0;
    int            ti = 0, tr = 0, cv = 0, bpLeft = 5, lastAcc = 0, post = 0;
    bit            hsT = 0, hsR = 0, hsRes = 0, doneRise = 0, finished = 0;

    for (int s = 0; s < NS; s++) tw[s] = basic ? ((s == 0) ? 32'd10 : 32'd500) : $urandom;
    for (int i = 0; i < ntrain; i++) begin
      trw.push_back(basic ? DW'(i + 1) : DW'($urandom));
      sum += int'(trw[i][15:0]);
    end
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < HK; k++) begin
        expq.push_back(16'(int'(tw[s][15:0]) + sum + k * 256 + ntrain * 4096));
        sidq.push_back(s);
        kidq.push_back(k);
      end

    @(negedge clk);
    start   = 1'b1;
    n_train = 16'(ntrain);
    @(negedge clk);
    start   = 1'b0;
    n_train = 16'($urandom);
    checkOutput("busy_start", busy, 1);

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (hsT) begin
        checkOutput("load_sel", core_solver_sel, ti - 1);
        checkOutput("load_data", core_data_1, tw[ti - 1]);
      end
      checkOutput("core_valid", core_valid, hsR);
      if (hsR) checkOutput("core_data_2", core_data_2, trw[tr - 1]);
      if (core_valid) begin
        cv++;
        checkOutput("done_in_stream", core_done, 0);
      end
      if (core_done && !doneRise) begin
        doneRise = 1;
        checkOutput("settle_len", cyc - lastAcc, 1 + SC);
      end
      checkOutput("test_ready", test_ready, ti < NS);
      checkOutput("train_ready", train_ready, ti == NS && tr < ntrain);

      if (post == 2) begin
        checkOutput("done_end", done, 0);
        checkOutput("busy_end", busy, 0);
        finished = 1;
      end else if (post == 1) begin
        checkOutput("done_pulse", done, 1);
        checkOutput("clr_pulse", core_clr, 1);
        checkOutput("core_done_clr", core_done, 0);
        post = 2;
      end else begin
        checkOutput("done_early", done, 0);
      end

      if (hsRes) begin
        hsRes = 0;
        checkOutput("res_gap", res_valid, 0);
      end
      if (bp && res_valid && expq.size() > 0 && sidq[0] == 1 && kidq[0] == 2 && bpLeft > 0) begin
        res_ready = 1'b0;
        bpLeft--;
      end else begin
        res_ready = (basic || bp) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      end
      if (res_valid) begin
        if (expq.size() == 0) begin
          checkOutput("res_extra", res_valid, 0);
        end else begin
          checkOutput("res_data", res_data, expq[0]);
          checkOutput("res_solver", res_solver, sidq[0]);
          checkOutput("res_k", res_k, kidq[0]);
          if (res_ready) begin
            hsRes = 1;
            void'(expq.pop_front());
            void'(sidq.pop_front());
            void'(kidq.pop_front());
            if (expq.size() == 0) post = 1;
          end
        end
      end

      hsT = 0;
      hsR = 0;
      if (ti == NS && tr < ntrain) begin
        train_valid = (gap == 0) ? 1'($urandom_range(0, 1)) : 1'(cyc % gap == 0);
        train_data  = train_valid ? trw[tr] : DW'($urandom);
        if (train_valid && train_ready) begin
          hsR = 1;
          tr++;
          lastAcc = cyc;
        end
      end else begin
        train_valid = 1'b0;
      end
      if (ti < NS) begin
        test_valid = (gap == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        test_data  = test_valid ? tw[ti] : DW'($urandom);
        if (test_valid && test_ready) begin
          hsT = 1;
          ti++;
          lastAcc = cyc;
        end
      end else begin
        test_valid = 1'b0;
      end
      start   = noise && (ti < NS || (doneRise && expq.size() > 2));
      n_train = 16'($urandom);

      if (!finished) @(negedge clk);
    end

    checkOutput("run_finished", finished, 1);
    checkOutput("valid_count", cv, ntrain);
    checkOutput("res_left", expq.size(), 0);
    start       = 1'b0;
    test_valid  = 1'b0;
    train_valid = 1'b0;
    res_ready   = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    start   = 1'b1;
    n_train = 16'd20;
    @(negedge clk);
    start      = 1'b0;
    test_valid = 1'b1;
    test_data  = $urandom;
    repeat (NS) @(negedge clk);
    test_valid  = 1'b0;
    train_valid = 1'b1;
    train_data  = $urandom;
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_stream", train_ready, 1);
    checkOutput("pre_rst_valid", core_valid, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_train_ready", train_ready, 0);
    checkOutput("rst_core_valid", core_valid, 0);
    checkOutput("rst_core_data_2", core_data_2, 0);
    checkOutput("rst_core_data_1", core_data_1, 0);
    train_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_done", done, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    n_train     = '0;
    test_data   = '0;
    test_valid  = 1'b0;
    train_data  = '0;
    train_valid = 1'b0;
    res_ready   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_res_valid", res_valid, 0);
    checkOutput("reset_core_done", core_done, 0);
    checkOutput("reset_core_sel", core_sel, 0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] basic run");
    applyStimulus(6, 1, 1, 0, 0);
    $display("[TB] gapped training stream");
    applyStimulus(33, 3, 0, 0, 0);
    $display("[TB] result backpressure");
    applyStimulus(5, 0, 0, 1, 0);
    $display("[TB] zero training points");
    applyStimulus(0, 1, 0, 0, 0);
    $display("[TB] start while busy");
    applyStimulus(4, 0, 0, 0, 1);
    applyStimulus(7, 0, 0, 0, 0);
    $display("[TB] reset mid-stream");
    applyReset();
    applyStimulus(3, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
